ft2232h_fifo_emulator: RTL and testbench
========================================

Name: ft2232h_fifo_emulator

Overview:
Synthesizable emulator of an FT2232H in FT245 synchronous-FIFO mode, used as the host side for FPGA streaming blocks such as the count streamer in simulation and loopback benches. It accepts bytes written by the FPGA into a TX FIFO and drains them at a fixed host rate. It generates host-to-FPGA bytes into an RX FIFO for the FPGA to read. It also checks that the accepted TX stream is a contiguous +1 byte sequence.

Parameters:
TX_DEPTH, 16, TX FIFO depth in bytes (power of 2, >=2).
RX_DEPTH, 16, RX FIFO depth in bytes (power of 2, >=2).
DRAIN_PERIOD, 4, host removes one TX byte every N clocks; 0 disables draining.
RX_FILL_PERIOD, 8, host pushes one RX byte every N clocks; 0 disables RX generation.
RX_SEED, 8'h00, first RX pattern byte.

Ports:
clk_i  in  1  60 MHz reference clock; all logic on rising edge.
reset_i  in  1  asynchronous, active-low reset.
clkout_o  out  1  clock to FPGA logic; equals clk_i combinationally.
data  inout  8  FT245 data bus.
rxf_o  out  1  active-low, RX data available.
txe_o  out  1  active-low, TX space available.
oe_i  in  1  active-low; FPGA requests the emulator to drive data.
rd_i  in  1  active-low read strobe.
wr_i  in  1  active-low write strobe.
tx_last_o  out  8  last byte accepted from FPGA.
tx_count_o  out  16  bytes accepted; wraps at 2^16.
tx_seq_err_o  out  1  sticky sequence-error flag.

Behaviour:
- Reset (reset_i=0, asynchronous):
  - Both FIFOs are emptied; drain and fill timers are set to 0.
  - The RX pattern register is loaded with RX_SEED.
  - txe_o=1, rxf_o=1, tx_last_o=0, tx_count_o=0, tx_seq_err_o=0.
  - The "first byte seen" flag is cleared and data is high-Z.
- txe_o and rxf_o are registered and computed from post-update occupancy:
  - txe_o <= (tx_count_next == TX_DEPTH).
  - rxf_o <= (rx_count_next == 0).
  - Consequence: txe_o falls on the first rising edge after reset release.
- TX accept: a byte is accepted at a rising edge when wr_i=0, txe_o=0 and oe_i=1. The byte sampled from data is pushed.
  - tx_last_o <= byte and tx_count_o increments.
  - If the first-seen flag is set and byte != tx_last_o+1 (mod 256), tx_seq_err_o <= 1. The flag stays set until reset.
  - The first-seen flag is then set. 0xFF followed by 0x00 is legal.
- TX writes are ignored, with no state change, when:
  - wr_i=0 and txe_o=1, or
  - wr_i=0 and oe_i=0 (bus turned toward FPGA).
- TX drain:
  - The timer counts 0..DRAIN_PERIOD-1 and wraps.
  - When it equals DRAIN_PERIOD-1 and the FIFO is non-empty, one byte is popped and discarded.
  - A push and pop on the same edge leave the count unchanged.
- RX fill:
  - The timer counts 0..RX_FILL_PERIOD-1.
  - At terminal count, if the RX FIFO is not full, the pattern byte is pushed and the pattern increments (mod 256).
  - If the FIFO is full, the slot is skipped and the pattern is not advanced.
- RX read:
  - While oe_i=0, data is driven with the RX FIFO head (0x00 when empty). Otherwise data is high-Z.
  - A pop occurs at a rising edge when oe_i=0, rd_i=0 and rxf_o=0. The next head appears on data after that edge.
  - rd_i=0 with rxf_o=1 is ignored.
  - Fill and pop on the same edge leave the count unchanged.
- FIFOs use binary read/write pointers plus an occupancy counter. They never overflow or underflow.
- Reset mid-operation discards all buffered data in both directions and clears all status immediately.

Test Plan:
1. Hold reset_i=0 for 2 clocks -> txe_o=1, rxf_o=1, data=Z, tx_count_o=0, tx_seq_err_o=0. Release reset -> txe_o=0 after the first edge.
2. Defaults; FPGA drives counter bytes 0x00,0x01,... with wr_i=0 whenever txe_o=0, oe_i=1 -> txe_o=1 once 16 bytes are buffered, then toggles as drain frees one byte every 4 clocks. tx_count_o equals bytes written, tx_last_o tracks the last byte, tx_seq_err_o stays 0.
3. Write 0x05 then 0x07 -> tx_seq_err_o=1 and remains 1 on later correct bytes. Write 0xFF then 0x00 (fresh reset) -> no error.
4. Fill TX, hold DRAIN_PERIOD=0, assert wr_i=0 with data 0xAA while txe_o=1 -> tx_count_o and tx_last_o unchanged. Same check with oe_i=0.
5. RX_FILL_PERIOD=8, oe_i=0, rd_i=0 whenever rxf_o=0 -> FPGA reads 0x00,0x01,0x02 in order. data=Z whenever oe_i=1.
6. Assert reset_i=0 mid-stream with both FIFOs non-empty -> outputs return to reset values immediately. After release, the first RX byte is RX_SEED.

Source files
------------

// File: rtl/ft2232h_fifo_emulator.sv
// Host-side model of an FT2232H in FT245 synchronous-FIFO mode.
// TX: accepts FPGA-written bytes, drains them at a fixed rate and checks
// that the accepted stream is a contiguous +1 sequence.
// RX: generates an incrementing byte pattern for the FPGA to read.
module ft2232h_fifo_emulator #(
    parameter int unsigned TX_DEPTH       = 16,
    parameter int unsigned RX_DEPTH       = 16,
    parameter int unsigned DRAIN_PERIOD   = 4,
    parameter int unsigned RX_FILL_PERIOD = 8,
    parameter logic [7:0]  RX_SEED        = 8'h00
) (
    input  logic        clk_i,
    input  logic        reset_i,
    output logic        clkout_o,
    inout  wire  [7:0]  data,
    output logic        rxf_o,
    output logic        txe_o,
    input  logic        oe_i,
    input  logic        rd_i,
    input  logic        wr_i,
    output logic [7:0]  tx_last_o,
    output logic [15:0] tx_count_o,
    output logic        tx_seq_err_o
);

    localparam int unsigned TX_AW = $clog2(TX_DEPTH);
    localparam int unsigned RX_AW = $clog2(RX_DEPTH);
    localparam int unsigned TX_CW = TX_AW + 1;
    localparam int unsigned RX_CW = RX_AW + 1;
    localparam int unsigned DT_W  = (DRAIN_PERIOD > 1) ? $clog2(DRAIN_PERIOD) : 1;
    localparam int unsigned FT_W  = (RX_FILL_PERIOD > 1) ? $clog2(RX_FILL_PERIOD) : 1;

    localparam logic [TX_CW-1:0] TX_FULL    = TX_CW'(TX_DEPTH);
    localparam logic [RX_CW-1:0] RX_FULL    = RX_CW'(RX_DEPTH);
    localparam logic [DT_W-1:0]  DRAIN_LAST = DT_W'((DRAIN_PERIOD > 0) ? DRAIN_PERIOD - 1 : 0);
    localparam logic [FT_W-1:0]  FILL_LAST  = FT_W'((RX_FILL_PERIOD > 0) ? RX_FILL_PERIOD - 1 : 0);

    // Timers
    logic [DT_W-1:0] drain_tmr_q, drain_tmr_d;
    logic [FT_W-1:0] fill_tmr_q, fill_tmr_d;
    logic            drain_tick, fill_tick;

    // TX side: drained bytes never leave the emulator, so only occupancy
    // is tracked; the stream itself is checked at accept time.
    logic [TX_CW-1:0] tx_cnt_q, tx_cnt_d;
    logic             txe_q, txe_d;
    logic [7:0]       tx_last_q, tx_last_d;
    logic [15:0]      tx_count_q, tx_count_d;
    logic             seq_err_q, seq_err_d;
    logic             first_q, first_d;
    logic             tx_push, tx_pop;
    logic [7:0]       data_in;

    // RX side
    logic [7:0]       rx_mem_q [RX_DEPTH];
    logic [RX_AW-1:0] rx_wptr_q, rx_wptr_d;
    logic [RX_AW-1:0] rx_rptr_q, rx_rptr_d;
    logic [RX_CW-1:0] rx_cnt_q, rx_cnt_d;
    logic [7:0]       rx_pat_q, rx_pat_d;
    logic             rxf_q, rxf_d;
    logic             rx_push, rx_pop;
    logic [7:0]       rx_head;

    assign clkout_o = clk_i;
    assign data_in  = data;
    assign rx_head  = (rx_cnt_q == '0) ? 8'h00 : rx_mem_q[rx_rptr_q];
    assign data     = oe_i ? 8'bzzzz_zzzz : rx_head;

    assign tx_push = ~wr_i & ~txe_q & oe_i;
    assign tx_pop  = drain_tick & (tx_cnt_q != '0);
    assign rx_push = fill_tick & (rx_cnt_q != RX_FULL);
    assign rx_pop  = ~oe_i & ~rd_i & ~rxf_q;

    // Free-running host timers; a period of 0 holds the timer and never ticks
    always_comb begin
        drain_tick  = 1'b0;
        drain_tmr_d = drain_tmr_q;
        fill_tick   = 1'b0;
        fill_tmr_d  = fill_tmr_q;
        if (DRAIN_PERIOD != 0) begin
            if (drain_tmr_q == DRAIN_LAST) begin
                drain_tick  = 1'b1;
                drain_tmr_d = '0;
            end else begin
                drain_tmr_d = drain_tmr_q + 1'b1;
            end
        end
        if (RX_FILL_PERIOD != 0) begin
            if (fill_tmr_q == FILL_LAST) begin
                fill_tick  = 1'b1;
                fill_tmr_d = '0;
            end else begin
                fill_tmr_d = fill_tmr_q + 1'b1;
            end
        end
    end

    // TX next state: occupancy, accepted-byte status and sequence check
    always_comb begin
        tx_cnt_d   = tx_cnt_q;
        tx_last_d  = tx_last_q;
        tx_count_d = tx_count_q;
        seq_err_d  = seq_err_q;
        first_d    = first_q;
        case ({tx_push, tx_pop})
            2'b10:   tx_cnt_d = tx_cnt_q + 1'b1;
            2'b01:   tx_cnt_d = tx_cnt_q - 1'b1;
            default: tx_cnt_d = tx_cnt_q;
        endcase
        if (tx_push) begin
            tx_last_d  = data_in;
            tx_count_d = tx_count_q + 16'd1;
            first_d    = 1'b1;
            if (first_q && (data_in != tx_last_q + 8'd1)) begin
                seq_err_d = 1'b1;
            end
        end
        txe_d = (tx_cnt_d == TX_FULL);
    end

    // RX next state: pointers, occupancy and pattern generator
    always_comb begin
        rx_wptr_d = rx_wptr_q;
        rx_rptr_d = rx_rptr_q;
        rx_pat_d  = rx_pat_q;
        case ({rx_push, rx_pop})
            2'b10:   rx_cnt_d = rx_cnt_q + 1'b1;
            2'b01:   rx_cnt_d = rx_cnt_q - 1'b1;
            default: rx_cnt_d = rx_cnt_q;
        endcase
        if (rx_push) begin
            rx_wptr_d = rx_wptr_q + 1'b1;
            rx_pat_d  = rx_pat_q + 8'd1;
        end
        if (rx_pop) begin
            rx_rptr_d = rx_rptr_q + 1'b1;
        end
        rxf_d = (rx_cnt_d == '0);
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            drain_tmr_q <= '0;
            fill_tmr_q  <= '0;
            tx_cnt_q    <= '0;
            txe_q       <= 1'b1;
            tx_last_q   <= '0;
            tx_count_q  <= '0;
            seq_err_q   <= 1'b0;
            first_q     <= 1'b0;
            rx_wptr_q   <= '0;
            rx_rptr_q   <= '0;
            rx_cnt_q    <= '0;
            rx_pat_q    <= RX_SEED;
            rxf_q       <= 1'b1;
        end else begin
            drain_tmr_q <= drain_tmr_d;
            fill_tmr_q  <= fill_tmr_d;
            tx_cnt_q    <= tx_cnt_d;
            txe_q       <= txe_d;
            tx_last_q   <= tx_last_d;
            tx_count_q  <= tx_count_d;
            seq_err_q   <= seq_err_d;
            first_q     <= first_d;
            rx_wptr_q   <= rx_wptr_d;
            rx_rptr_q   <= rx_rptr_d;
            rx_cnt_q    <= rx_cnt_d;
            rx_pat_q    <= rx_pat_d;
            rxf_q       <= rxf_d;
        end
    end

    // RX storage; contents are qualified by occupancy so no reset is needed
    always_ff @(posedge clk_i) begin
        if (rx_push) begin
            rx_mem_q[rx_wptr_q] <= rx_pat_q;
        end
    end

    assign txe_o        = txe_q;
    assign rxf_o        = rxf_q;
    assign tx_last_o    = tx_last_q;
    assign tx_count_o   = tx_count_q;
    assign tx_seq_err_o = seq_err_q;

endmodule

// File: tb/tb_ft2232h_fifo_emulator.sv
// Directed bench for ft2232h_fifo_emulator: one instance with default
// timing, one with draining and RX generation disabled.
module tb_ft2232h_fifo_emulator;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Default instance
    logic        rst_n, oe, rd, wr, drv;
    logic [7:0]  dat;
    wire  [7:0]  data;
    logic        clkout, rxf, txe, seq_err;
    logic [7:0]  tx_last;
    logic [15:0] tx_count;
    assign data = drv ? dat : 8'bzzzz_zzzz;

    ft2232h_fifo_emulator dut (
        .clk_i(clk), .reset_i(rst_n), .clkout_o(clkout), .data(data),
        .rxf_o(rxf), .txe_o(txe), .oe_i(oe), .rd_i(rd), .wr_i(wr),
        .tx_last_o(tx_last), .tx_count_o(tx_count), .tx_seq_err_o(seq_err)
    );

    // No-drain, no-fill instance
    logic        rst2, oe2, rd2, wr2, drv2;
    logic [7:0]  dat2;
    wire  [7:0]  data2;
    logic        clkout2, rxf2, txe2, seq_err2;
    logic [7:0]  tx_last2;
    logic [15:0] tx_count2;
    assign data2 = drv2 ? dat2 : 8'bzzzz_zzzz;

    ft2232h_fifo_emulator #(.DRAIN_PERIOD(0), .RX_FILL_PERIOD(0)) dut2 (
        .clk_i(clk), .reset_i(rst2), .clkout_o(clkout2), .data(data2),
        .rxf_o(rxf2), .txe_o(txe2), .oe_i(oe2), .rd_i(rd2), .wr_i(wr2),
        .tx_last_o(tx_last2), .tx_count_o(tx_count2), .tx_seq_err_o(seq_err2)
    );

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reset ends on a falling edge; the next falling edge follows edge P1.
    task automatic do_reset();
        rst_n = 1'b0; wr = 1'b1; rd = 1'b1; oe = 1'b1; drv = 1'b1; dat = 8'h00;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic do_reset2();
        rst2 = 1'b0; wr2 = 1'b1; rd2 = 1'b1; oe2 = 1'b1; drv2 = 1'b1; dat2 = 8'h00;
        repeat (2) @(negedge clk);
        rst2 = 1'b1;
    endtask

    task automatic write_byte(input logic [7:0] b);
        int n = 0;
        while (txe !== 1'b0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 50) begin
            $display("FAIL write_timeout: txe=%b required 0 within 50 cycles", txe);
            errors++;
        end
        wr = 1'b0; dat = b;
        @(negedge clk);
        wr = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; wr = 1'b1; rd = 1'b1; oe = 1'b1; drv = 1'b1; dat = 8'hA5;
        repeat (2) @(negedge clk);
        checks++; if (txe !== 1'b1) begin $display("FAIL rst_txe: got %b want 1", txe); errors++; end
        checks++; if (rxf !== 1'b1) begin $display("FAIL rst_rxf: got %b want 1", rxf); errors++; end
        checks++; if (tx_count !== 16'd0) begin $display("FAIL rst_count: got %0d want 0", tx_count); errors++; end
        checks++; if (tx_last !== 8'h00) begin $display("FAIL rst_last: got %h want 00", tx_last); errors++; end
        checks++; if (seq_err !== 1'b0) begin $display("FAIL rst_seq: got %b want 0", seq_err); errors++; end
        checks++; if (data !== 8'hA5) begin $display("FAIL rst_data_z: got %h want A5 (bus released)", data); errors++; end
        checks++; if (clkout !== 1'b0) begin $display("FAIL clkout: got %b want 0", clkout); errors++; end
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (txe !== 1'b0) begin $display("FAIL rel_txe: got %b want 0", txe); errors++; end
        checks++; if (rxf !== 1'b1) begin $display("FAIL rel_rxf: got %b want 1", rxf); errors++; end
    endtask

    task automatic test_back_to_back();
        logic [7:0] nxt = 8'h00;
        int written = 0;
        do_reset();
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (k == 21) begin
                checks++; if (txe !== 1'b0) begin $display("FAIL stream_txe21: got %b want 0", txe); errors++; end
            end
            if (k == 22) begin
                checks++; if (txe !== 1'b1) begin $display("FAIL stream_txe22: got %b want 1", txe); errors++; end
                checks++; if (tx_count !== 16'd21) begin $display("FAIL stream_cnt22: got %0d want 21", tx_count); errors++; end
                checks++; if (tx_last !== 8'd20) begin $display("FAIL stream_last22: got %h want 14", tx_last); errors++; end
            end
            if (k == 23) begin
                checks++; if (txe !== 1'b1) begin $display("FAIL stream_txe23: got %b want 1", txe); errors++; end
            end
            if (k == 24) begin
                checks++; if (txe !== 1'b0) begin $display("FAIL stream_txe24: got %b want 0", txe); errors++; end
            end
            if (k == 25) begin
                checks++; if (txe !== 1'b1) begin $display("FAIL stream_txe25: got %b want 1", txe); errors++; end
            end
            if (txe === 1'b0) begin
                wr = 1'b0; dat = nxt; nxt = nxt + 8'd1; written++;
            end else begin
                wr = 1'b1;
            end
        end
        @(negedge clk);
        wr = 1'b1;
        checks++; if (tx_count !== 16'(written)) begin $display("FAIL stream_count: got %0d want %0d", tx_count, written); errors++; end
        checks++; if (tx_last !== nxt - 8'd1) begin $display("FAIL stream_last: got %h want %h", tx_last, nxt - 8'd1); errors++; end
        checks++; if (seq_err !== 1'b0) begin $display("FAIL stream_seq: got %b want 0", seq_err); errors++; end
    endtask

    task automatic test_seq_err();
        do_reset();
        write_byte(8'h05);
        write_byte(8'h07);
        checks++; if (seq_err !== 1'b1) begin $display("FAIL seq_gap: got %b want 1", seq_err); errors++; end
        checks++; if (tx_last !== 8'h07) begin $display("FAIL seq_last: got %h want 07", tx_last); errors++; end
        write_byte(8'h08);
        checks++; if (seq_err !== 1'b1) begin $display("FAIL seq_sticky: got %b want 1", seq_err); errors++; end
        checks++; if (tx_count !== 16'd3) begin $display("FAIL seq_count: got %0d want 3", tx_count); errors++; end
        do_reset();
        write_byte(8'hFF);
        write_byte(8'h00);
        write_byte(8'h01);
        checks++; if (seq_err !== 1'b0) begin $display("FAIL seq_wrap: got %b want 0", seq_err); errors++; end
        checks++; if (tx_last !== 8'h01) begin $display("FAIL wrap_last: got %h want 01", tx_last); errors++; end
        checks++; if (tx_count !== 16'd3) begin $display("FAIL wrap_count: got %0d want 3", tx_count); errors++; end
    endtask

    task automatic test_ignored_writes();
        do_reset2();
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            wr2 = 1'b0; dat2 = 8'h0F + 8'(k);
        end
        @(negedge clk);
        checks++; if (txe2 !== 1'b1) begin $display("FAIL full_txe: got %b want 1", txe2); errors++; end
        checks++; if (tx_count2 !== 16'd16) begin $display("FAIL full_count: got %0d want 16", tx_count2); errors++; end
        checks++; if (tx_last2 !== 8'h1F) begin $display("FAIL full_last: got %h want 1F", tx_last2); errors++; end
        wr2 = 1'b0; dat2 = 8'hAA;
        repeat (4) @(negedge clk);
        wr2 = 1'b1;
        checks++; if (tx_count2 !== 16'd16) begin $display("FAIL ign_full_count: got %0d want 16", tx_count2); errors++; end
        checks++; if (tx_last2 !== 8'h1F) begin $display("FAIL ign_full_last: got %h want 1F", tx_last2); errors++; end
        checks++; if (seq_err2 !== 1'b0) begin $display("FAIL ign_full_seq: got %b want 0", seq_err2); errors++; end
        do_reset2();
        @(negedge clk);
        oe2 = 1'b0; drv2 = 1'b0; wr2 = 1'b0;
        #1;
        checks++; if (data2 !== 8'h00) begin $display("FAIL empty_head: got %h want 00", data2); errors++; end
        repeat (4) @(negedge clk);
        checks++; if (tx_count2 !== 16'd0) begin $display("FAIL ign_oe_count: got %0d want 0", tx_count2); errors++; end
        checks++; if (txe2 !== 1'b0) begin $display("FAIL ign_oe_txe: got %b want 0", txe2); errors++; end
        checks++; if (rxf2 !== 1'b1) begin $display("FAIL nofill_rxf: got %b want 1", rxf2); errors++; end
        wr2 = 1'b1; oe2 = 1'b1;
    endtask

    task automatic test_rx_read();
        do_reset();
        oe = 1'b0; drv = 1'b0;
        for (int k = 1; k <= 33; k++) begin
            @(negedge clk);
            #1;
            if (k == 7) begin
                checks++; if (rxf !== 1'b1) begin $display("FAIL rx_rxf7: got %b want 1", rxf); errors++; end
            end
            if (k == 8) begin
                checks++; if (rxf !== 1'b0) begin $display("FAIL rx_rxf8: got %b want 0", rxf); errors++; end
            end
            if (k == 24) begin
                checks++; if (data !== 8'h00) begin $display("FAIL rx_b0: got %h want 00", data); errors++; end
                rd = 1'b0;
            end
            if (k == 25) begin
                checks++; if (data !== 8'h01) begin $display("FAIL rx_b1: got %h want 01", data); errors++; end
                rd = 1'b1; oe = 1'b0;
                oe = 1'b1; drv = 1'b1; dat = 8'h5A;
                #1;
                checks++; if (data !== 8'h5A) begin $display("FAIL rx_z: got %h want 5A (bus released)", data); errors++; end
            end
            if (k == 26) begin
                oe = 1'b0; drv = 1'b0;
                #1;
                checks++; if (data !== 8'h01) begin $display("FAIL rx_hold: got %h want 01", data); errors++; end
                rd = 1'b0;
            end
            if (k == 27) begin
                checks++; if (data !== 8'h02) begin $display("FAIL rx_b2: got %h want 02", data); errors++; end
            end
            if (k == 28) begin
                checks++; if (rxf !== 1'b1) begin $display("FAIL rx_empty: got %b want 1", rxf); errors++; end
                checks++; if (data !== 8'h00) begin $display("FAIL rx_empty_data: got %h want 00", data); errors++; end
            end
            if (k == 32) begin
                checks++; if (rxf !== 1'b0) begin $display("FAIL rx_refill: got %b want 0", rxf); errors++; end
                checks++; if (data !== 8'h03) begin $display("FAIL rx_b3: got %h want 03", data); errors++; end
            end
            if (k == 33) begin
                checks++; if (rxf !== 1'b1) begin $display("FAIL rx_pop3: got %b want 1", rxf); errors++; end
            end
        end
        rd = 1'b1; oe = 1'b1; drv = 1'b1;
    endtask

    task automatic test_reset_mid();
        int n = 0;
        do_reset();
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            wr = 1'b0;
            dat = (k == 5) ? 8'h77 : 8'(k);
        end
        wr = 1'b1;
        checks++; if (rxf !== 1'b0) begin $display("FAIL mid_rxf: got %b want 0", rxf); errors++; end
        checks++; if (tx_count !== 16'd19) begin $display("FAIL mid_count: got %0d want 19", tx_count); errors++; end
        checks++; if (seq_err !== 1'b1) begin $display("FAIL mid_seq: got %b want 1", seq_err); errors++; end
        rst_n = 1'b0;
        #1;
        checks++; if (txe !== 1'b1) begin $display("FAIL arst_txe: got %b want 1", txe); errors++; end
        checks++; if (rxf !== 1'b1) begin $display("FAIL arst_rxf: got %b want 1", rxf); errors++; end
        checks++; if (tx_count !== 16'd0) begin $display("FAIL arst_count: got %0d want 0", tx_count); errors++; end
        checks++; if (tx_last !== 8'h00) begin $display("FAIL arst_last: got %h want 00", tx_last); errors++; end
        checks++; if (seq_err !== 1'b0) begin $display("FAIL arst_seq: got %b want 0", seq_err); errors++; end
        @(negedge clk);
        rst_n = 1'b1; oe = 1'b0; drv = 1'b0;
        while (rxf !== 1'b0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++; if (n != 8) begin $display("FAIL seed_latency: got %0d cycles want 8", n); errors++; end
        checks++; if (data !== 8'h00) begin $display("FAIL seed_data: got %h want 00", data); errors++; end
        oe = 1'b1; drv = 1'b1;
    endtask

    initial begin
        rst2 = 1'b0; wr2 = 1'b1; rd2 = 1'b1; oe2 = 1'b1; drv2 = 1'b1; dat2 = 8'h00;
        test_reset();
        test_back_to_back();
        test_seq_err();
        test_ignored_writes();
        test_rx_read();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
